// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package if_prefetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] inst_addr_bus_t;
    typedef logic [INST_W-1:0]      inst_bus_t;

    typedef enum logic [1:0] {
        FETCH_IDLE = 2'd0,
        FETCH_WAIT = 2'd1,
        FETCH_DROP = 2'd2
    } fetch_state_e;

    localparam inst_addr_bus_t PC_INC = 32'd4;

    // Instruction addresses are always word aligned.
    function automatic inst_addr_bus_t align_word(input inst_addr_bus_t addr);
        return {addr[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue: small synchronous FIFO with flush, head visible from storage.
module if_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Entry storage; no reset needed since reads are qualified by count.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch: single-outstanding fetch FSM feeding a small queue.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// FETCH_IDLE | no request outstanding; issue next cycle if queue has room
// FETCH_WAIT | request outstanding for fetch_pc; data is pushed on done
// FETCH_DROP | outstanding request went stale after a redirect; discard it
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int             DEPTH    = 4,
    parameter inst_addr_bus_t RESET_PC = 32'h0
) (
    input  logic           clk,
    input  logic           rst_n,
    output logic           ram_req_o,
    output inst_addr_bus_t ram_addr_o,
    input  logic           ram_done_i,
    input  inst_bus_t      ram_inst_i,
    output logic           inst_valid_o,
    output inst_bus_t      inst_o,
    output inst_addr_bus_t pc_o,
    input  logic           id_ready_i,
    input  logic           jump_i,
    input  inst_addr_bus_t jump_pc_i,
    output logic           stall_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e   state_q, state_d;
    inst_addr_bus_t fetch_pc_q, fetch_pc_d;
    inst_addr_bus_t req_addr_q, req_addr_d;

    logic             push;
    logic             pop;
    logic [63:0]      head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // State, fetch PC and the address held on the bus for the current request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH_IDLE;
            fetch_pc_q <= RESET_PC;
            req_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Next-state logic; a redirect always wins over a returning fetch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        unique case (state_q)
            FETCH_IDLE: begin
                if (jump_i) begin
                    fetch_pc_d = align_word(jump_pc_i);
                end else if (!fifo_full) begin
                    state_d    = FETCH_WAIT;
                    req_addr_d = fetch_pc_q;
                end
            end
            FETCH_WAIT: begin
                if (jump_i) begin
                    fetch_pc_d = align_word(jump_pc_i);
                    state_d    = ram_done_i ? FETCH_IDLE : FETCH_DROP;
                end else if (ram_done_i) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INC;
                    state_d    = FETCH_IDLE;
                end
            end
            FETCH_DROP: begin
                // The bus keeps the old address until memory answers it.
                if (jump_i)     fetch_pc_d = align_word(jump_pc_i);
                if (ram_done_i) state_d    = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    assign pop = inst_valid_o & id_ready_i;

    if_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data ({fetch_pc_q, ram_inst_i}),
        .pop       (pop),
        .flush     (jump_i),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign ram_req_o    = (state_q != FETCH_IDLE);
    assign ram_addr_o   = req_addr_q;
    assign inst_valid_o = (fifo_count != '0);
    assign stall_o      = fifo_empty;
    assign inst_o       = inst_valid_o ? head[31:0]  : '0;
    assign pc_o         = inst_valid_o ? head[63:32] : '0;

endmodule

// File: tb/tb_if_prefetch.sv
// Bench: DEPTH=4 and DEPTH=2 prefetchers driven in lockstep, checked against a queue model.
module tb_if_prefetch;

    localparam int          N        = 2;
    localparam logic [31:0] INST_OFS = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_ready;
    logic        jump;
    logic [31:0] jump_pc;

    logic        ram_req    [N];
    logic [31:0] ram_addr   [N];
    logic        ram_done   [N];
    logic [31:0] ram_inst   [N];
    logic        inst_valid [N];
    logic [31:0] inst       [N];
    logic [31:0] pc         [N];
    logic        stall      [N];

    int   mem_lat;
    logic mem_stray;
    int   mem_cnt [N];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        if_prefetch #(
            .DEPTH    ((g == 0) ? 4 : 2),
            .RESET_PC (32'h0)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .ram_req_o    (ram_req[g]),
            .ram_addr_o   (ram_addr[g]),
            .ram_done_i   (ram_done[g]),
            .ram_inst_i   (ram_inst[g]),
            .inst_valid_o (inst_valid[g]),
            .inst_o       (inst[g]),
            .pc_o         (pc[g]),
            .id_ready_i   (id_ready),
            .jump_i       (jump),
            .jump_pc_i    (jump_pc),
            .stall_o      (stall[g])
        );
    end

    task automatic chk(input string what, input int g, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d at %0t: got %h expected %h", what, g, $time, act, exp);
        end
    endtask

    // Memory: answers the request in its mem_lat-th cycle with inst = addr + INST_OFS.
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < N; g++) begin
            if (!rst_n) begin
                mem_cnt[g]  = 0;
                ram_done[g] = mem_stray;
                ram_inst[g] = 32'hDEAD_BEEF;
            end else if (ram_req[g]) begin
                mem_cnt[g]++;
                if (mem_cnt[g] >= mem_lat) begin
                    ram_done[g] = 1'b1;
                    ram_inst[g] = ram_addr[g] + INST_OFS;
                    mem_cnt[g]  = 0;
                end else begin
                    ram_done[g] = 1'b0;
                end
            end else begin
                mem_cnt[g]  = 0;
                ram_done[g] = 1'b0;
            end
        end
    end

    // Behavioural model: a queue of {pc, inst}, the fetch PC, and whether a
    // request is outstanding / stale. Checked on every falling edge.
    logic [63:0] mq [N][$];
    logic [31:0] m_fpc   [N];
    logic [31:0] m_raddr [N];
    bit          m_out   [N];
    bit          m_stale [N];
    logic [63:0] m_head;
    bit          m_valid;
    int          m_n;

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (!rst_n) begin
                mq[g].delete();
                m_fpc[g]   = 32'h0;
                m_raddr[g] = 32'h0;
                m_out[g]   = 1'b0;
                m_stale[g] = 1'b0;
            end
            m_n     = mq[g].size();
            m_valid = (m_n != 0);
            m_head  = m_valid ? mq[g][0] : 64'h0;
            chk("inst_valid", g, 32'(inst_valid[g]), 32'(m_valid));
            chk("stall", g, 32'(stall[g]), 32'(!m_valid));
            chk("pc", g, pc[g], m_head[63:32]);
            chk("inst", g, inst[g], m_head[31:0]);
            chk("ram_req", g, 32'(ram_req[g]), 32'(m_out[g]));
            if (m_out[g]) chk("ram_addr", g, ram_addr[g], m_raddr[g]);
            if (rst_n) begin
                if (jump) begin
                    mq[g].delete();
                    if (m_out[g]) begin
                        if (ram_done[g]) begin
                            m_out[g]   = 1'b0;
                            m_stale[g] = 1'b0;
                        end else begin
                            m_stale[g] = 1'b1;
                        end
                    end
                    m_fpc[g] = {jump_pc[31:2], 2'b00};
                end else begin
                    if (m_valid && id_ready) void'(mq[g].pop_front());
                    if (m_out[g] && ram_done[g]) begin
                        if (!m_stale[g]) begin
                            mq[g].push_back({m_fpc[g], ram_inst[g]});
                            m_fpc[g] = m_fpc[g] + 32'd4;
                        end
                        m_out[g]   = 1'b0;
                        m_stale[g] = 1'b0;
                    end else if (!m_out[g] && m_n < ((g == 0) ? 4 : 2)) begin
                        m_out[g]   = 1'b1;
                        m_raddr[g] = m_fpc[g];
                    end
                end
            end
        end
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic do_reset(input logic rdy, input int lat);
        @(posedge clk);
        #2;
        rst_n     = 1'b0;
        id_ready  = rdy;
        jump      = 1'b0;
        jump_pc   = 32'h0;
        mem_lat   = lat;
        mem_stray = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string what);
        for (int g = 0; g < N; g++) begin
            chk({what, "_valid"}, g, 32'(inst_valid[g]), 32'h0);
            chk({what, "_stall"}, g, 32'(stall[g]), 32'h1);
            chk({what, "_req"}, g, 32'(ram_req[g]), 32'h0);
            chk({what, "_pc"}, g, pc[g], 32'h0);
            chk({what, "_inst"}, g, inst[g], 32'h0);
        end
    endtask

    initial begin
        int          w;
        logic [31:0] exp_pc;
        logic [31:0] pat;

        rst_n     = 1'b0;
        id_ready  = 1'b1;
        jump      = 1'b0;
        jump_pc   = 32'h0;
        mem_lat   = 1;
        mem_stray = 1'b0;

        // Reset values and first fetch at RESET_PC right after release.
        #3;
        chk_reset_outputs("rst");
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("first_req", 0, 32'(ram_req[0]), 32'h1);
        chk("first_addr", 0, ram_addr[0], 32'h0);

        // Single-cycle memory, decode always ready: 0,4,8,... one per two cycles.
        exp_pc = 32'h0;
        for (int i = 0; i < 30; i++) begin
            if (inst_valid[0]) begin
                chk("seq_pc", 0, pc[0], exp_pc);
                chk("seq_inst", 0, inst[0], exp_pc + INST_OFS);
                exp_pc = exp_pc + 32'd4;
            end
            step(1);
        end
        chk("throughput", 0, exp_pc, 32'd60);

        // Decode stalled: queue fills to DEPTH and fetching stops, nothing lost.
        do_reset(1'b0, 1);
        step(20);
        chk("fill_req", 0, 32'(ram_req[0]), 32'h0);
        chk("fill_req", 1, 32'(ram_req[1]), 32'h0);
        id_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("fill_pc", 0, pc[0], 32'(4 * k));
            if (k < 2) chk("fill_pc", 1, pc[1], 32'(4 * k));
            step(1);
        end

        // Latency 5, redirect to 0x100 in the second WAIT cycle.
        do_reset(1'b1, 5);
        step(2);
        jump    = 1'b1;
        jump_pc = 32'h100;
        step(1);
        jump = 1'b0;
        chk("drop_req", 0, 32'(ram_req[0]), 32'h1);
        chk("drop_addr", 0, ram_addr[0], 32'h0);
        w = 0;
        while (!inst_valid[0] && w < 40) begin
            step(1);
            w++;
        end
        chk("drop_arrive", 0, 32'(inst_valid[0]), 32'h1);
        chk("drop_pc", 0, pc[0], 32'h100);
        chk("drop_inst", 0, inst[0], 32'h1000_0100);

        // Redirect coinciding with ram_done and a pop; target low bits ignored.
        do_reset(1'b0, 1);
        w = 0;
        while (!(ram_done[0] && inst_valid[0]) && w < 20) begin
            step(1);
            w++;
        end
        chk("coinc_setup", 0, 32'(ram_done[0] & inst_valid[0]), 32'h1);
        id_ready = 1'b1;
        jump     = 1'b1;
        jump_pc  = 32'h203;
        step(1);
        jump = 1'b0;
        chk("coinc_flush", 0, 32'(inst_valid[0]), 32'h0);
        chk("coinc_idle", 0, 32'(ram_req[0]), 32'h0);
        step(1);
        chk("coinc_req", 0, 32'(ram_req[0]), 32'h1);
        chk("coinc_addr", 0, ram_addr[0], 32'h200);

        // Irregular decode readiness: order preserved across pointer wrap (DEPTH=2).
        do_reset(1'b1, 1);
        pat    = 32'b1100_0111_0010_0110_0011_1100_0101_0001;
        exp_pc = 32'h0;
        for (int i = 0; i < 32; i++) begin
            id_ready = pat[i];
            if (inst_valid[1] && id_ready) begin
                chk("wrap_pc", 1, pc[1], exp_pc);
                exp_pc = exp_pc + 32'd4;
            end
            step(1);
        end
        id_ready = 1'b1;

        // Reset asserted mid-WAIT, stray done while idle after release.
        do_reset(1'b1, 5);
        step(3);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        mem_stray = 1'b1;
        step(1);
        rst_n     = 1'b1;
        mem_stray = 1'b0;
        chk("stray_idle", 0, 32'(ram_req[0]), 32'h0);
        step(1);
        chk("restart_req", 0, 32'(ram_req[0]), 32'h1);
        chk("restart_addr", 0, ram_addr[0], 32'h0);
        chk("stray_nopush", 0, 32'(inst_valid[0]), 32'h0);
        w = 0;
        while (!inst_valid[0] && w < 40) begin
            step(1);
            w++;
        end
        chk("restart_pc", 0, pc[0], 32'h0);
        chk("restart_inst", 0, inst[0], INST_OFS);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch.md
IF_PREFETCH -- requirements
Module: if_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, prefetch queue entries; power of two, >= 2.
REQ-002 Parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ram_req_o  output  1  instruction-memory read request, held high until accepted.
REQ-006 ram_addr_o  output  32  word-aligned fetch address, stable while ram_req_o high.
REQ-007 ram_done_i  input  1  one-cycle pulse: ram_inst_i valid for the outstanding request.
REQ-008 ram_inst_i  input  32  fetched instruction.
REQ-009 inst_valid_o  output  1  queue head valid.
REQ-010 inst_o  output  32  queue-head instruction; 0 when inst_valid_o low.
REQ-011 pc_o  output  32  queue-head PC; 0 when inst_valid_o low.
REQ-012 id_ready_i  input  1  decode accepts head this cycle (pop = inst_valid_o & id_ready_i).
REQ-013 jump_i  input  1  redirect pulse from execute.
REQ-014 jump_pc_i  input  32  redirect target.
REQ-015 stall_o  output  1  high whenever inst_valid_o is low.

Function
REQ-016 Fetch FSM states: IDLE (no request outstanding), WAIT (request outstanding), DROP (outstanding request is stale).
REQ-017 IDLE->WAIT when count+0 < DEPTH and no jump_i; ram_req_o high in WAIT/DROP only, address = fetch_pc.
REQ-018 WAIT, ram_done_i, no jump_i: push {fetch_pc, ram_inst_i}, fetch_pc += 4, ->IDLE; next request issues earliest next cycle.
REQ-019 WAIT, jump_i (with or without ram_done_i): data dropped; fetch_pc <= jump_pc_i; ->IDLE if ram_done_i this cycle, else ->DROP.
REQ-020 DROP: ram_req_o stays high with old address; on ram_done_i discard data, ->IDLE.
REQ-021 DROP, further jump_i: fetch_pc updated to newest target, stay DROP.
REQ-022 IDLE, jump_i: fetch_pc <= jump_pc_i, no request that cycle.
REQ-023 jump_i flushes queue same edge (count <= 0); flush overrides simultaneous pop and push.
REQ-024 Queue FIFO order; head visible combinationally from registered storage, zero extra latency.
REQ-025 Simultaneous push and pop: count unchanged, both performed, legal at full and at count 1.
REQ-026 Request issued only if count < DEPTH, so push never overflows; pop on empty impossible by REQ-012.
REQ-027 Read/write pointers log2(DEPTH) bits, wrap naturally; count log2(DEPTH)+1 bits.
REQ-028 fetch_pc arithmetic mod 2^32; 32'hFFFFFFFC+4 wraps to 0.
REQ-029 Minimum steady-state throughput: one instruction per two cycles with single-cycle memory.
REQ-030 jump_pc_i low two bits are ignored (forced 0).

Reset
REQ-031 rst_n low: FSM=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, ram_req_o=0, inst_valid_o=0, inst_o=0, pc_o=0, stall_o=1.
REQ-032 Reset mid-WAIT abandons request; a ram_done_i arriving after reset release with no request outstanding is ignored.
REQ-033 First request issues in the first cycle after rst_n deasserts.

Structure
REQ-034 Shared package/defines hold InstAddrBus, InstBus, fetch-state encodings and the PC increment constant.
REQ-035 Queue is one sub-module if_fifo (params DEPTH, WIDTH=64, ports push, pop, flush, full, empty, count); FSM and fetch_pc in if_prefetch.

Verification
REQ-036 Reset, memory 1-cycle latency, id_ready_i=1 -> PCs 0,4,8,... with correct words, ram_addr_o starts 0.
REQ-037 id_ready_i=0 for 20 cycles, DEPTH=4 -> exactly 4 entries queued (PCs 0..12), ram_req_o low after fill, no loss.
REQ-038 Memory latency 5, jump_i to 0x100 at cycle 2 of WAIT -> stale word discarded, next pushed PC 0x100, queue empty meanwhile.
REQ-039 jump_i coincident with ram_done_i and pop -> nothing pushed, queue flushed, next request addr = jump target.
REQ-040 Full queue with simultaneous pop and ram_done_i (DEPTH=2 config) -> count stays, order preserved across pointer wrap.
REQ-041 rst_n pulsed low mid-WAIT -> all outputs at reset values asynchronously; restart fetch at RESET_PC.
